ic_irq_source: RTL and testbench

Peripheral-side interrupt requester that drives the `irq_in` inputs of the interrupt controller. It accepts single-cycle event pulses from up to N_IRQ peripherals and queues them per channel in saturating counters. It issues one single-cycle request pulse per queued event, then holds that channel outstanding until the CPU-side acknowledge names that channel. Unacknowledged requests are re-pulsed after a programmable timeout, so events are neither lost nor double-counted by the pending-register/ack protocol.

---
 rtl/ic_irq_source_if.sv | 24 ++
 rtl/ic_irq_source.sv | 102 ++++++++++
 tb/tb_ic_irq_source.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ic_irq_source_if.sv
// Interface between the peripheral-side event/ack signals and the interrupt requester.
interface ic_irq_source_if #(
  parameter int N_IRQ = 8,
  parameter int IDW   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
);
  logic [N_IRQ-1:0] event_in;
  logic             ack_in;
  logic [IDW-1:0]   ack_id;
  logic [N_IRQ-1:0] clr_overflow;
  logic [N_IRQ-1:0] irq_req;
  logic [N_IRQ-1:0] outstanding;
  logic [N_IRQ-1:0] overflow;
  logic [N_IRQ-1:0] retry_pulse;

  modport master (
    output event_in, ack_in, ack_id, clr_overflow,
    input  irq_req, outstanding, overflow, retry_pulse
  );

  modport slave (
    input  event_in, ack_in, ack_id, clr_overflow,
    output irq_req, outstanding, overflow, retry_pulse
  );
endinterface

// File: rtl/ic_irq_source.sv
// Per-channel interrupt requester: queues events in saturating counters, pulses irq_req
// once per event, holds the channel until acknowledged and re-pulses after a timeout.
module ic_irq_source #(
  parameter int N_IRQ   = 8,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 64
) (
  input logic           clk,
  input logic           rstn,
  ic_irq_source_if.slave bus
);
  localparam int IDW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, FIRE, WAIT} state_t;

  state_t           state     [N_IRQ];
  state_t           state_nxt [N_IRQ];
  logic [CNT_W-1:0] cnt       [N_IRQ];
  logic [CNT_W-1:0] cnt_nxt   [N_IRQ];
  logic [TW-1:0]    timer     [N_IRQ];
  logic [TW-1:0]    timer_nxt [N_IRQ];
  logic [N_IRQ-1:0] ovf_nxt;
  logic [N_IRQ-1:0] rty_nxt;
  logic [N_IRQ-1:0] req_nxt;
  logic [N_IRQ-1:0] out_nxt;
  logic [N_IRQ-1:0] ack_hit;
  logic [N_IRQ-1:0] start;

  always_comb begin
    ovf_nxt = '0;
    rty_nxt = '0;
    req_nxt = '0;
    out_nxt = '0;
    ack_hit = '0;
    start   = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      timer_nxt[i] = timer[i];
      // ack_id values outside the channel range never match any i
      ack_hit[i]   = bus.ack_in && (bus.ack_id == IDW'(i));
      start[i]     = (state[i] == IDLE) && (cnt[i] != '0);
      ovf_nxt[i]   = bus.overflow[i] && !bus.clr_overflow[i];

      case (state[i])
        IDLE: if (start[i]) state_nxt[i] = FIRE;
        FIRE: begin
          timer_nxt[i] = '0;
          state_nxt[i] = ack_hit[i] ? IDLE : WAIT;
        end
        WAIT: begin
          if (ack_hit[i]) begin
            state_nxt[i] = IDLE;
          end else if (TIMEOUT != 0 && timer[i] == TMAX) begin
            state_nxt[i] = FIRE;
            rty_nxt[i]   = 1'b1;
          end else if (TIMEOUT != 0) begin
            timer_nxt[i] = timer[i] + TW'(1);
          end
        end
        default: state_nxt[i] = IDLE;
      endcase

      // Set of overflow overrides a same-cycle clear
      if (bus.event_in[i] && !start[i]) begin
        if (cnt[i] == '1) ovf_nxt[i] = 1'b1;
        else              cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end else if (!bus.event_in[i] && start[i]) begin
        cnt_nxt[i] = cnt[i] - CNT_W'(1);
      end

      req_nxt[i] = (state_nxt[i] == FIRE);
      out_nxt[i] = (state_nxt[i] != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < N_IRQ; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
        timer[i] <= '0;
      end
      bus.irq_req     <= '0;
      bus.outstanding <= '0;
      bus.overflow    <= '0;
      bus.retry_pulse <= '0;
    end else begin
      for (int unsigned i = 0; i < N_IRQ; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
        timer[i] <= timer_nxt[i];
      end
      bus.irq_req     <= req_nxt;
      bus.outstanding <= out_nxt;
      bus.overflow    <= ovf_nxt;
      bus.retry_pulse <= rty_nxt;
    end
  end
endmodule

// File: tb/tb_ic_irq_source.sv
// Scoreboard bench for ic_irq_source: stimulus queues expected request pulses,
// a negedge monitor pops and compares whenever a request or retry strobe appears.
module tb_ic_irq_source;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  typedef struct {
    int         cyc;
    logic [7:0] req;
    logic [7:0] rty;
  } exp_t;
  exp_t q[$];

  ic_irq_source_if #(.N_IRQ(8), .IDW(3)) bus ();
  ic_irq_source #(.N_IRQ(8), .CNT_W(4), .TIMEOUT(4)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn === 1'b1 && (bus.irq_req !== 8'h00 || bus.retry_pulse !== 8'h00)) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: cycle %0d irq_req=%h retry=%h, none required",
                 cyc, bus.irq_req, bus.retry_pulse);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.req !== bus.irq_req || e.rty !== bus.retry_pulse) begin
          n_fail++;
          $display("FAIL pulse: got cycle %0d irq_req=%h retry=%h, required cycle %0d irq_req=%h retry=%h",
                   cyc, bus.irq_req, bus.retry_pulse, e.cyc, e.req, e.rty);
        end
      end
    end
  end

  task automatic push(input int c, input logic [7:0] req, input logic [7:0] rty);
    exp_t e;
    e.cyc = c; e.req = req; e.rty = rty;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Inputs set here are sampled on the next rising edge; returns one cycle later.
  task automatic drive(input logic [7:0] ev, input logic ack, input logic [2:0] id,
                       input logic [7:0] clr);
    bus.event_in     = ev;
    bus.ack_in       = ack;
    bus.ack_id       = id;
    bus.clr_overflow = clr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(8'h00, 1'b0, 3'd0, 8'h00);
  endtask

  initial begin
    int c;
    bus.event_in = '0; bus.ack_in = 1'b0; bus.ack_id = '0; bus.clr_overflow = '0;
    repeat (3) @(negedge clk);
    chk("rst_irq_req", bus.irq_req, 8'h00);
    chk("rst_outstanding", bus.outstanding, 8'h00);
    chk("rst_overflow", bus.overflow, 8'h00);
    chk("rst_retry", bus.retry_pulse, 8'h00);
    rstn = 1'b1;
    idle(2);

    // Single event on channel 3, acked while waiting
    c = cyc;
    push(c + 2, 8'h08, 8'h00);
    drive(8'h08, 1'b0, 3'd0, 8'h00);
    chk("t1_out_c1", bus.outstanding, 8'h00);
    idle(1);
    chk("t1_out_c2", bus.outstanding, 8'h08);
    idle(1);
    chk("t1_out_c3", bus.outstanding, 8'h08);
    idle(1);
    chk("t1_out_c4", bus.outstanding, 8'h08);
    drive(8'h00, 1'b1, 3'd3, 8'h00);
    chk("t1_out_after_ack", bus.outstanding, 8'h00);
    idle(8);

    // Three queued events on channel 0, each request acked two cycles later
    c = cyc;
    push(c + 2, 8'h01, 8'h00);
    push(c + 5, 8'h01, 8'h00);
    push(c + 8, 8'h01, 8'h00);
    for (int k = 0; k < 3; k++) drive(8'h01, 1'b0, 3'd0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      drive(8'h00, 1'b1, 3'd0, 8'h00);
      idle(2);
    end
    idle(5);
    chk("t2_out_end", bus.outstanding, 8'h00);

    // Saturation on channel 5 with retries, then event+decrement at max and drain
    c = cyc;
    push(c + 2, 8'h20, 8'h00);
    push(c + 7, 8'h20, 8'h20);
    push(c + 12, 8'h20, 8'h20);
    push(c + 17, 8'h20, 8'h20);
    for (int k = 0; k < 16; k++) push(c + 22 + 3 * k, 8'h20, 8'h00);
    for (int k = 0; k < 20; k++) drive(8'h20, 1'b0, 3'd0, 8'h00);
    chk("t3_overflow_set", bus.overflow, 8'h20);
    chk("t3_out_sat", bus.outstanding, 8'h20);
    drive(8'h00, 1'b1, 3'd5, 8'h00);
    chk("t3_overflow_held", bus.overflow, 8'h20);
    drive(8'h20, 1'b0, 3'd0, 8'h20);
    chk("t3_overflow_clr", bus.overflow, 8'h00);
    for (int k = 0; k < 16; k++) begin
      idle(1);
      drive(8'h00, 1'b1, 3'd5, 8'h00);
      idle(1);
    end
    idle(8);
    chk("t3_out_drained", bus.outstanding, 8'h00);
    chk("t3_overflow_end", bus.overflow, 8'h00);

    // Retry on channel 2: pulses at t, t+5, t+10, then ack while waiting
    c = cyc;
    push(c + 2, 8'h04, 8'h00);
    push(c + 7, 8'h04, 8'h04);
    push(c + 12, 8'h04, 8'h04);
    drive(8'h04, 1'b0, 3'd0, 8'h00);
    idle(12);
    drive(8'h00, 1'b1, 3'd2, 8'h00);
    idle(10);
    chk("t4_out_end", bus.outstanding, 8'h00);

    // Simultaneous channels 1 and 6; ack in FIRE, ack in WAIT, ack to an idle channel
    c = cyc;
    push(c + 2, 8'h42, 8'h00);
    drive(8'h42, 1'b0, 3'd0, 8'h00);
    idle(1);
    drive(8'h00, 1'b1, 3'd1, 8'h00);
    chk("t5_fire_ack", bus.outstanding, 8'h40);
    idle(1);
    drive(8'h00, 1'b1, 3'd6, 8'h00);
    chk("t5_wait_ack", bus.outstanding, 8'h00);
    drive(8'h00, 1'b1, 3'd4, 8'h00);
    chk("t5_idle_ack", bus.outstanding, 8'h00);
    idle(6);

    // Reset while channel 7 waits with cnt=7
    c = cyc;
    push(c + 2, 8'h80, 8'h00);
    push(c + 7, 8'h80, 8'h80);
    for (int k = 0; k < 8; k++) drive(8'h80, 1'b0, 3'd0, 8'h00);
    bus.event_in = '0;
    chk("t6_out_before_rst", bus.outstanding, 8'h80);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_irq_req", bus.irq_req, 8'h00);
    chk("t6_rst_outstanding", bus.outstanding, 8'h00);
    chk("t6_rst_retry", bus.retry_pulse, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    idle(20);
    chk("t6_out_after_rst", bus.outstanding, 8'h00);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pulses: got %0d still queued, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
